// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master and its peripherals.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } apb_state_e;

  localparam int APB_DATA_W = 32;
  // Wide enough to index up to eight slaves.
  localparam int SEL_W      = 3;

  localparam logic [3:0] TX_FIFO_OFS = 4'h8;
  localparam logic [3:0] RX_FIFO_OFS = 4'hC;

  localparam int SLV_UART  = 0;
  localparam int SLV_GPIO  = 1;
  localparam int SLV_TIMER = 2;
  localparam int SLV_AUX   = 3;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational decode of a CPU byte address into an APB slave index.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int          NUM_SLV       = 4,
  parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
  parameter int          SLV_SIZE_LOG2 = 12
) (
  input  logic [31:0]      addr,
  output logic [SEL_W-1:0] sel_idx,
  output logic             valid
);

  logic [31:0] ofs;
  logic [31:0] idx_full;

  // Addresses below the base wrap to a huge offset, so the base check is still needed.
  always_comb begin
    ofs      = addr - BASE_ADDR;
    idx_full = ofs >> SLV_SIZE_LOG2;
    valid    = (addr >= BASE_ADDR) && (idx_full < 32'(NUM_SLV));
    sel_idx  = idx_full[SEL_W-1:0];
  end

endmodule

// File: rtl/apb_master.sv
// CPU simple-bus to APB bridge with decode-error and PREADY-timeout protection.
//   state  | meaning
//   IDLE   | waiting for req; captures address/data/direction
//   SETUP  | PSEL raised, PENABLE low, one cycle
//   ACCESS | PSEL+PENABLE, waiting for PREADY or timeout
//   DONE   | one-cycle ready pulse with rdata/err
module apb_master
  import apb_pkg::*;
#(
  parameter int          NUM_SLV       = 4,
  parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
  parameter int          SLV_SIZE_LOG2 = 12,
  parameter int          TIMEOUT       = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    req,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  input  logic                    we,
  output logic [31:0]             rdata,
  output logic                    ready,
  output logic                    err,
  output logic [31:0]             PADDR,
  output logic [31:0]             PWDATA,
  output logic                    PWRITE,
  output logic                    PENABLE,
  output logic [NUM_SLV-1:0]      PSEL,
  input  logic [NUM_SLV*32-1:0]   PRDATA,
  input  logic [NUM_SLV-1:0]      PREADY
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  apb_state_e              state;
  logic [CNT_W-1:0]        cnt;
  logic [SEL_W-1:0]        dec_idx;
  logic                    dec_valid;
  logic [NUM_SLV-1:0]      dec_oh;
  logic [APB_DATA_W-1:0]   prdata_sel;
  logic                    slv_ready;

  apb_addr_decoder #(
    .NUM_SLV      (NUM_SLV),
    .BASE_ADDR    (BASE_ADDR),
    .SLV_SIZE_LOG2(SLV_SIZE_LOG2)
  ) u_dec (
    .addr   (addr),
    .sel_idx(dec_idx),
    .valid  (dec_valid)
  );

  // PSEL is the registered one-hot select, so it doubles as the mux control.
  always_comb begin
    dec_oh     = '0;
    prdata_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      dec_oh[i] = (dec_idx == SEL_W'(i));
      if (PSEL[i]) prdata_sel = PRDATA[i*APB_DATA_W +: APB_DATA_W];
    end
    slv_ready = |(PREADY & PSEL);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      PWRITE  <= 1'b0;
      PENABLE <= 1'b0;
      PSEL    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            PADDR  <= addr;
            PWDATA <= wdata;
            PWRITE <= we;
            if (dec_valid) begin
              PSEL  <= dec_oh;
              state <= ST_SETUP;
            end else begin
              ready <= 1'b1;
              err   <= 1'b1;
              rdata <= '0;
              state <= ST_DONE;
            end
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          cnt <= cnt + 1'b1;
          if (slv_ready) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            ready   <= 1'b1;
            err     <= 1'b0;
            rdata   <= PWRITE ? '0 : prdata_sel;
            state   <= ST_DONE;
          end else if (cnt == CNT_W'(TIMEOUT-1)) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            ready   <= 1'b1;
            err     <= 1'b1;
            rdata   <= '0;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          ready <= 1'b0;
          err   <= 1'b0;
          rdata <= '0;
          cnt   <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Bridges the CPU-side simple request bus to the APB peripheral bus.
- Decodes the address, drives PSEL/PENABLE/PADDR/PWDATA/PWRITE to one of several slaves (UART, GPIO, timer…), and muxes PRDATA/PREADY back.
- Sits directly upstream of every APB peripheral, including the UART peripheral whose TX FIFO is at offset 0x8 and RX FIFO at offset 0xC.
- Adds address-decode error and PREADY-timeout protection so a bad access cannot hang the CPU.

Parameters:
- NUM_SLV, 4, number of APB slaves (1..8).
- BASE_ADDR, 32'h1000_0000, base of the APB region.
- SLV_SIZE_LOG2, 12, each slave window is 2^12 bytes; slave i occupies BASE_ADDR + i*0x1000.
- TIMEOUT, 16, max cycles spent in ACCESS waiting for PREADY before abort (>=2).

Ports:
- PCLK  in  1  system clock, all logic rising-edge.
- PRESET  in  1  synchronous, active-high reset.
- req  in  1  CPU request; sampled only in IDLE.
- addr  in  32  CPU byte address.
- wdata  in  32  CPU write data.
- we  in  1  1 = write, 0 = read.
- rdata  out  32  read data, valid while ready=1.
- ready  out  1  one-cycle transaction-complete pulse.
- err  out  1  valid with ready: decode error or timeout.
- PADDR  out  32  captured CPU address (slaves use low bits).
- PWDATA  out  32  captured write data.
- PWRITE  out  1  captured direction.
- PENABLE  out  1  APB access phase.
- PSEL  out  NUM_SLV  one-hot slave select.
- PRDATA  in  NUM_SLV*32  slave read data, slave i at bits [32*i+31:32*i].
- PREADY  in  NUM_SLV  per-slave ready.

Behaviour:
- Reset (synchronous, takes effect at the PCLK edge with PRESET=1)
  - All outputs are 0.
  - State is IDLE and the timeout counter is 0.
  - Reset overrides any state, including mid-ACCESS; there is no completion pulse for an aborted transfer.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE
  - PSEL=0, PENABLE=0.
  - If req=1 at an edge: capture addr/wdata/we into PADDR/PWDATA/PWRITE and compute sel_idx = (addr - BASE_ADDR) >> SLV_SIZE_LOG2.
  - Valid when addr >= BASE_ADDR and sel_idx < NUM_SLV → next state SETUP.
  - Otherwise → DONE with err_r=1 and rdata_r=0. No PSEL is ever raised.
- SETUP: PSEL[sel_idx]=1, PENABLE=0, lasts exactly 1 cycle → ACCESS.
- ACCESS
  - PSEL[sel_idx]=1, PENABLE=1; the counter increments each cycle.
  - If PREADY[sel_idx]=1 at an edge: rdata_r = PRDATA slice sel_idx if PWRITE=0, else 0; err_r=0 → DONE.
  - Else if counter == TIMEOUT-1: err_r=1, rdata_r=0 → DONE.
  - PREADY of non-selected slaves is ignored.
- DONE
  - PSEL=0, PENABLE=0; ready=1, rdata=rdata_r, err=err_r for exactly 1 cycle → IDLE.
  - The counter clears.
- Latency, req sampled at edge 0:
  - SETUP in cycle 1, ACCESS in cycle 2, ready in cycle 3 when PREADY=1 in the first ACCESS cycle.
  - Each PREADY wait cycle adds 1.
  - Decode error gives ready in cycle 1.
- PADDR/PWDATA/PWRITE hold stable from SETUP through DONE. They are updated only on an IDLE capture.
- req held high: a new transaction is captured in the IDLE cycle after DONE. Minimum back-to-back spacing is 4 cycles (IDLE, SETUP, ACCESS, DONE). Requests are never lost or duplicated while req stays high.
- rdata/err are 0 whenever ready=0.

Decomposition:
- Package apb_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, DONE);
  - APB_DATA_W=32;
  - UART register offsets (TX_FIFO_OFS=4'h8, RX_FIFO_OFS=4'hC);
  - slave index constants.
- One natural sub-module: apb_addr_decoder. It is combinational: addr → sel_idx, valid.
- FSM, capture registers, timeout counter and read mux stay in apb_master.

Test Plan:
- Write, zero wait state: req, addr=0x1000_2008, we=1, wdata=0xA5, PREADY[2] tied 1.
  - Cycle 1: PSEL=4'b0100, PENABLE=0, PADDR[3:0]=8, PWDATA=0xA5.
  - Cycle 2: PENABLE=1.
  - Cycle 3: ready=1, err=0, rdata=0.
- Read with waits: addr=0x1000_300C, we=0; slave 3 asserts PREADY 3 cycles into ACCESS with PRDATA[127:96]=0x3C.
  - Expect ready in cycle 5, rdata=0x3C, err=0.
  - PSEL held at 4'b1000 for 4 cycles; PREADY[0..2] toggling has no effect.
- Decode error, both cases give ready=1, err=1, rdata=0 in cycle 1 and PSEL never nonzero:
  - addr=0x2000_0000;
  - addr=0x1000_4000 with NUM_SLV=4.
- Timeout: addr=0x1000_0000, PREADY[0]=0 forever.
  - ACCESS lasts 16 cycles, then ready=1, err=1, rdata=0.
  - PSEL/PENABLE drop to 0 in DONE.
  - A following read to slave 1 completes normally.
- Reset mid-ACCESS: PRESET=1 for one edge during a waiting ACCESS.
  - Next cycle: all outputs 0, no ready pulse.
  - A fresh request after reset completes with nominal 3-cycle latency.
- Back-to-back: req held high for two writes (slave 2, 0x11 then 0x22).
  - Exactly two ready pulses, 4 cycles apart.
  - PWDATA changes only in the IDLE capture between them.
